// File: rtl/button_shaper_multi.sv
// Multi-channel push-button shaper: 2-flop synchroniser, debounce, registered
// press/release pulses and optional per-channel auto-repeat, all in the Clk domain.
module button_shaper_multi #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned ACTIVE_LOW   = 1,
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned REPEAT_DELAY = 16,
  parameter int unsigned REPEAT_RATE  = 4
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [N_CH-1:0] Bin,
  input  logic [N_CH-1:0] RepeatEn,
  output logic [N_CH-1:0] Bout,
  output logic [N_CH-1:0] Held,
  output logic [N_CH-1:0] Release
);

  localparam int unsigned DW   = $clog2(DEB_CYCLES + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = $clog2(RMAX + 1);
  localparam logic        REL  = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  logic [N_CH-1:0] sync1_q;
  logic [N_CH-1:0] sync2_q;
  logic [N_CH-1:0] pressed;

  // Two-flop synchroniser; reset loads the released level so no phantom press appears
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1_q <= {N_CH{REL}};
      sync2_q <= {N_CH{REL}};
    end else begin
      sync1_q <= Bin;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = sync2_q ^ {N_CH{REL}};

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_e        state_q, state_d;
    logic [DW-1:0] deb_q, deb_d;
    logic          s_q, s_d;
    logic [RW-1:0] rpt_q, rpt_d;
    logic          bout_q, bout_d;
    logic          rel_q, rel_d;

    // Debounce: S flips only after DEB_CYCLES consecutive disagreeing samples
    always_comb begin
      s_d   = s_q;
      deb_d = '0;
      if (pressed[c] != s_q) begin
        if (deb_q == DW'(DEB_CYCLES - 1)) begin
          s_d   = ~s_q;
          deb_d = '0;
        end else begin
          deb_d = deb_q + DW'(1);
        end
      end
    end

    always_ff @(posedge Clk) begin
      if (Rst) begin
        state_q <= ST_IDLE;
      end else begin
        state_q <= state_d;
      end
    end

    always_ff @(posedge Clk) begin
      if (Rst) begin
        deb_q  <= '0;
        s_q    <= 1'b0;
        rpt_q  <= '0;
        bout_q <= 1'b0;
        rel_q  <= 1'b0;
      end else begin
        deb_q  <= deb_d;
        s_q    <= s_d;
        rpt_q  <= rpt_d;
        bout_q <= bout_d;
        rel_q  <= rel_d;
      end
    end

    // Next state; decisions use the incoming debounced level so pulses align with Held
    always_comb begin
      state_d = state_q;
      unique case (state_q)
        ST_IDLE: begin
          if (s_d) state_d = ST_DELAY;
        end
        ST_DELAY: begin
          if (!s_d) begin
            state_d = ST_IDLE;
          end else if (RepeatEn[c] && (rpt_q == RW'(REPEAT_DELAY - 1))) begin
            state_d = ST_REPEAT;
          end
        end
        ST_REPEAT: begin
          if (!s_d) begin
            state_d = ST_IDLE;
          end else if (!RepeatEn[c]) begin
            state_d = ST_DELAY;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Pulses and repeat counter; a falling S always wins over a due repeat
    always_comb begin
      bout_d = 1'b0;
      rel_d  = 1'b0;
      rpt_d  = rpt_q;
      unique case (state_q)
        ST_IDLE: begin
          rpt_d = '0;
          if (s_d) bout_d = 1'b1;
        end
        ST_DELAY: begin
          if (!s_d) begin
            rel_d = 1'b1;
            rpt_d = '0;
          end else if (!RepeatEn[c]) begin
            rpt_d = '0;
          end else if (rpt_q == RW'(REPEAT_DELAY - 1)) begin
            bout_d = 1'b1;
            rpt_d  = '0;
          end else begin
            rpt_d = rpt_q + RW'(1);
          end
        end
        ST_REPEAT: begin
          if (!s_d) begin
            rel_d = 1'b1;
            rpt_d = '0;
          end else if (!RepeatEn[c]) begin
            rpt_d = '0;
          end else if (rpt_q == RW'(REPEAT_RATE - 1)) begin
            bout_d = 1'b1;
            rpt_d  = '0;
          end else begin
            rpt_d = rpt_q + RW'(1);
          end
        end
        default: rpt_d = '0;
      endcase
    end

    assign Bout[c]    = bout_q;
    assign Held[c]    = s_q;
    assign Release[c] = rel_q;
  end

endmodule

// File: tb/tb_button_shaper_multi.sv
// Self-checking bench for button_shaper_multi: vector table, directed corner
// sequences, and random stimulus against a window/arithmetic reference model.
module tb_button_shaper_multi;

  localparam int N       = 4;
  localparam int DEB     = 4;
  localparam int RD      = 16;
  localparam int RR      = 4;
  localparam int TBL_LEN = 34;

  typedef struct packed {
    logic         rst;
    logic [N-1:0] bin;
    logic [N-1:0] rep;
    logic [N-1:0] bout;
    logic [N-1:0] held;
    logic [N-1:0] rel;
  } vec_t;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [N-1:0] Bin, RepeatEn;
  logic [N-1:0] Bout, Held, Release;
  logic [N-1:0] bin_hi, bout_hi, held_hi, rel_hi;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 Clk = ~Clk;

  assign bin_hi = ~Bin;

  button_shaper_multi #(
    .N_CH(N), .ACTIVE_LOW(1), .DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Bin(Bin), .RepeatEn(RepeatEn),
    .Bout(Bout), .Held(Held), .Release(Release)
  );

  button_shaper_multi #(
    .N_CH(N), .ACTIVE_LOW(0), .DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut_hi (
    .Clk(Clk), .Rst(Rst), .Bin(bin_hi), .RepeatEn(RepeatEn),
    .Bout(bout_hi), .Held(held_hi), .Release(rel_hi)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  // Reference model: a raw sample reaches the debouncer two edges later; the level
  // flips when the last DEB post-reset samples all disagree with it. Repeats fire
  // at RD + k*RR edges after the latest anchor (press, or an edge with RepeatEn low).
  bit [1:0]     m_pipe   [N];
  bit           m_win    [N][DEB];
  int           m_valid  [N];
  bit           m_s      [N];
  int           m_anchor [N];
  logic [N-1:0] e_bout = '0, e_held = '0, e_rel = '0;

  initial begin
    forever begin
      @(posedge Clk);
      cyc++;
      e_bout = '0;
      e_rel  = '0;
      for (int c = 0; c < N; c++) begin
        if (Rst) begin
          m_pipe[c]   = 2'b00;
          m_valid[c]  = 0;
          m_s[c]      = 1'b0;
          m_anchor[c] = 0;
          for (int j = 0; j < DEB; j++) m_win[c][j] = 1'b0;
        end else begin
          bit p, flip;
          int d;
          p         = m_pipe[c][1];
          m_pipe[c] = {m_pipe[c][0], ~Bin[c]};
          for (int j = DEB - 1; j > 0; j--) m_win[c][j] = m_win[c][j-1];
          m_win[c][0] = p;
          if (m_valid[c] < DEB) m_valid[c]++;
          flip = (m_valid[c] >= DEB);
          for (int j = 0; j < DEB; j++) if (m_win[c][j] == m_s[c]) flip = 1'b0;
          if (flip && !m_s[c]) begin
            m_s[c]      = 1'b1;
            e_bout[c]   = 1'b1;
            m_anchor[c] = cyc;
          end else if (flip) begin
            m_s[c]   = 1'b0;
            e_rel[c] = 1'b1;
          end else if (m_s[c]) begin
            if (!RepeatEn[c]) begin
              m_anchor[c] = cyc;
            end else begin
              d = cyc - m_anchor[c];
              if (d >= RD && ((d - RD) % RR) == 0) e_bout[c] = 1'b1;
            end
          end
        end
        e_held[c] = m_s[c];
      end
    end
  end

  // Per-cycle comparison of both polarity builds against the model, plus pulse capture
  int cap_ch = 0;
  int cap_b[$];
  int cap_r[$];

  initial begin
    forever begin
      @(negedge Clk);
      if (cyc > 0) begin
        check("model.bout",    32'(Bout),    32'(e_bout));
        check("model.held",    32'(Held),    32'(e_held));
        check("model.release", 32'(Release), 32'(e_rel));
        check("model_hi.bout",    32'(bout_hi), 32'(e_bout));
        check("model_hi.held",    32'(held_hi), 32'(e_held));
        check("model_hi.release", 32'(rel_hi),  32'(e_rel));
        if (Bout[cap_ch])    cap_b.push_back(cyc);
        if (Release[cap_ch]) cap_r.push_back(cyc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  vec_t vt [TBL_LEN];
  int   e0, e1, r, n_before, rate, rel_edge, t;
  int   exp_b[$];
  bit   found;

  initial begin
    Rst      = 1'b1;
    Bin      = '1;
    RepeatEn = '0;

    // Clean press on ch0, bounce on ch1, ch2/ch3 idle
    for (int i = 0; i < TBL_LEN; i++) begin
      vt[i].rst = (i < 2);
      vt[i].bin = '1;
      vt[i].rep = '0;
      if (i >= 4 && i < 24) vt[i].bin[0] = 1'b0;
      if ((i >= 4 && i < 7) || (i >= 8 && i < 10)) vt[i].bin[1] = 1'b0;
      vt[i].bout = '0;
      vt[i].held = '0;
      vt[i].rel  = '0;
      vt[i].held[0] = (i >= 4 + DEB + 1) && (i < 24 + DEB + 1);
      vt[i].bout[0] = (i == 4 + DEB + 1);
      vt[i].rel[0]  = (i == 24 + DEB + 1);
    end

    for (int i = 0; i < TBL_LEN; i++) begin
      Rst      = vt[i].rst;
      Bin      = vt[i].bin;
      RepeatEn = vt[i].rep;
      @(posedge Clk);
      tick();
      check($sformatf("tbl[%0d].bout", i),    32'(Bout),    32'(vt[i].bout));
      check($sformatf("tbl[%0d].held", i),    32'(Held),    32'(vt[i].held));
      check($sformatf("tbl[%0d].release", i), 32'(Release), 32'(vt[i].rel));
    end

    // Auto-repeat on ch2, released on the edge a repeat would fall due
    cap_ch = 2;
    cap_b.delete();
    cap_r.delete();
    Bin[2]      = 1'b0;
    RepeatEn[2] = 1'b1;
    e0 = cyc + 1;
    repeat (40) tick();
    Bin[2] = 1'b1;
    repeat (15) tick();
    rel_edge = e0 + 40 + DEB + 1;
    exp_b.delete();
    exp_b.push_back(e0 + DEB + 1);
    t = e0 + DEB + 1 + RD;
    while (t < rel_edge) begin
      exp_b.push_back(t);
      t += RR;
    end
    check("repeat.count", 32'(cap_b.size()), 32'(exp_b.size()));
    for (int k = 0; k < exp_b.size() && k < cap_b.size(); k++)
      check($sformatf("repeat.pulse%0d", k), 32'(cap_b[k]), 32'(exp_b[k]));
    check("repeat.release_count", 32'(cap_r.size()), 32'd1);
    if (cap_r.size() > 0) check("repeat.release_edge", 32'(cap_r[0]), 32'(rel_edge));
    RepeatEn[2] = 1'b0;

    // RepeatEn dropped after two repeats, then restored
    cap_b.delete();
    cap_r.delete();
    Bin[2]      = 1'b0;
    RepeatEn[2] = 1'b1;
    for (int k = 0; k < 60 && cap_b.size() < 3; k++) tick();
    check("toggle.two_repeats_seen", 32'(cap_b.size() >= 3), 32'd1);
    RepeatEn[2] = 1'b0;
    n_before = cap_b.size();
    repeat (10) tick();
    check("toggle.quiet_while_off", 32'(cap_b.size()), 32'(n_before));
    RepeatEn[2] = 1'b1;
    e1 = cyc + 1;
    repeat (22) tick();
    check("toggle.pulses_after_on", 32'(cap_b.size()), 32'(n_before + 2));
    if (cap_b.size() >= n_before + 2) begin
      check("toggle.first_after_on",  32'(cap_b[n_before]),     32'(e1 + RD - 1));
      check("toggle.second_after_on", 32'(cap_b[n_before + 1]), 32'(e1 + RD - 1 + RR));
    end
    Bin[2] = 1'b1;
    repeat (10) tick();
    RepeatEn[2] = 1'b0;

    // Simultaneous press on ch0 and ch3
    cap_ch = 0;
    Bin[0] = 1'b0;
    Bin[3] = 1'b0;
    e0 = cyc + 1;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (Bout != '0) begin
        check("simul.bout",    32'(Bout),    32'b1001);
        check("simul.bout_hi", 32'(bout_hi), 32'b1001);
        check("simul.edge",    32'(cyc),     32'(e0 + DEB + 1));
        found = 1'b1;
        break;
      end
    end
    check("simul.seen", 32'(found), 32'd1);
    tick();
    check("simul.one_cycle", 32'(Bout), 32'd0);
    Bin = '1;
    repeat (10) tick();

    // Reset while ch0 is repeating and still held
    cap_b.delete();
    RepeatEn[0] = 1'b1;
    Bin[0]      = 1'b0;
    for (int k = 0; k < 60 && cap_b.size() < 2; k++) tick();
    check("rstmid.in_repeat", 32'(cap_b.size() >= 2), 32'd1);
    Rst = 1'b1;
    r = cyc + 1;
    tick();
    check("rstmid.bout0",    32'(Bout),    32'd0);
    check("rstmid.held0",    32'(Held),    32'd0);
    check("rstmid.release0", 32'(Release), 32'd0);
    tick();
    check("rstmid.bout1", 32'(Bout), 32'd0);
    check("rstmid.held1", 32'(Held), 32'd0);
    Rst = 1'b0;
    cap_b.delete();
    repeat (26) tick();
    check("rstmid.count", 32'(cap_b.size()), 32'd3);
    if (cap_b.size() >= 3) begin
      check("rstmid.press",   32'(cap_b[0]), 32'(r + DEB + 3));
      check("rstmid.repeat1", 32'(cap_b[1]), 32'(r + DEB + 3 + RD));
      check("rstmid.repeat2", 32'(cap_b[2]), 32'(r + DEB + 3 + RD + RR));
    end
    Bin         = '1;
    RepeatEn[0] = 1'b0;
    repeat (10) tick();

    // Random segments with varying bounce density
    rate = 8;
    for (int k = 0; k < 4000; k++) begin
      if (k % 200 == 0) rate = $urandom_range(2, 40);
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, rate) == 0) Bin[c] = ~Bin[c];
      if ($urandom_range(0, 31) == 0) RepeatEn = 4'($urandom);
      Rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    Rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
